// File: rtl/edge_gate_ctrl_if.sv
// Bundles the signals of edge_gate_ctrl, apart from clock and reset.
//   master : drives strobe, start/stop, continuous, align, gate length and result ready
//   slave  : the measurement block; returns busy, gate, result, result valid and overrun
// Parameters CNT_W and GATE_W must match those of the attached edge_gate_ctrl.
interface edge_gate_ctrl_if #(
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned GATE_W = 32
);

  logic              strobe_i;
  logic              start_i;
  logic              stop_i;
  logic              continuous_i;
  logic              align_i;
  logic [GATE_W-1:0] gate_len_i;
  logic              busy_o;
  logic              gate_o;
  logic [CNT_W-1:0]  result_o;
  logic              result_valid_o;
  logic              result_ready_i;
  logic              overrun_o;

  modport master (
    output strobe_i, start_i, stop_i, continuous_i, align_i, gate_len_i, result_ready_i,
    input  busy_o, gate_o, result_o, result_valid_o, overrun_o
  );

  modport slave (
    input  strobe_i, start_i, stop_i, continuous_i, align_i, gate_len_i, result_ready_i,
    output busy_o, gate_o, result_o, result_valid_o, overrun_o
  );

endinterface

// File: rtl/edge_gate_ctrl.sv
// Gated edge counter: synchronises strobe_i, detects the selected edge, opens a gate
// window of gate_len_i clocks and counts edges only while the gate is open. At gate
// close the count is offered on a valid/ready result register; an unread result is
// kept and the new one dropped with overrun_o raised. Single-shot or continuous,
// with optional alignment of the gate start to the first edge.
//
// Ports:
//   clk_i  : clock
//   rst_i  : asynchronous, active-high reset
//   bus    : edge_gate_ctrl_if.slave
//            strobe_i, start_i, stop_i, continuous_i, align_i, gate_len_i, result_ready_i (in)
//            busy_o, gate_o, result_o, result_valid_o, overrun_o (out)
//
// Build option: define EDGE_GATE_SAT_EN to saturate the count at all-ones (and flag
// it on overrun_o) instead of wrapping modulo 2^CNT_W.
module edge_gate_ctrl #(
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned GATE_W   = 32,
  parameter logic        POLARITY = 1'b1
) (
  input logic              clk_i,
  input logic              rst_i,
  edge_gate_ctrl_if.slave  bus
);

`ifdef EDGE_GATE_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    GATE = 2'd2
  } state_t;

  state_t            state, state_n;

  logic [3:0]        sr;
  logic              edge_det;

  logic [GATE_W-1:0] len_r;
  logic [GATE_W-1:0] timer;
  logic [CNT_W-1:0]  count;
  logic              sat_r;

  logic [CNT_W-1:0]  cnt_inc;
  logic [CNT_W-1:0]  final_cnt;
  logic              cnt_max;
  logic              final_sat;

  logic              start_acc;
  logic              arm_hit;
  logic              gate_step;
  logic              gate_close;
  logic              abort;

  logic              busy_q;
  logic              gate_q;
  logic              valid_q;
  logic              overrun_q;
  logic [CNT_W-1:0]  result_q;

  // Strobe synchroniser / edge pipeline; reset to the idle level so no edge follows reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sr <= {4{~POLARITY}};
    end else begin
      sr <= {sr[2:0], bus.strobe_i};
    end
  end

  assign edge_det = (sr[3] != POLARITY) && (sr[2] == POLARITY);

  // Count increment, saturating only when the build option is on
  always_comb begin
    cnt_max   = (count == {CNT_W{1'b1}});
    cnt_inc   = (SAT_EN && cnt_max) ? count : count + CNT_W'(1);
    final_cnt = edge_det ? cnt_inc : count;
    final_sat = SAT_EN && (sat_r || (edge_det && cnt_max));
  end

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state and datapath control strobes
  always_comb begin
    state_n    = state;
    start_acc  = 1'b0;
    arm_hit    = 1'b0;
    gate_step  = 1'b0;
    gate_close = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start_i && (bus.gate_len_i != '0)) begin
          start_acc = 1'b1;
          state_n   = bus.align_i ? ARM : GATE;
        end
      end
      ARM: begin
        if (bus.stop_i) begin
          abort   = 1'b1;
          state_n = IDLE;
        end else if (edge_det) begin
          arm_hit = 1'b1;
          state_n = GATE;
        end
      end
      GATE: begin
        // stop beats a coincident gate close
        if (bus.stop_i) begin
          abort   = 1'b1;
          state_n = IDLE;
        end else if (timer == len_r) begin
          gate_close = 1'b1;
          state_n    = bus.continuous_i ? GATE : IDLE;
        end else begin
          gate_step = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Gate timer, edge count, result register and status flags
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      len_r     <= '0;
      timer     <= '0;
      count     <= '0;
      sat_r     <= 1'b0;
      result_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      busy_q    <= 1'b0;
      gate_q    <= 1'b0;
    end else begin
      busy_q <= (state_n != IDLE);
      gate_q <= (state_n == GATE);

      if (start_acc) begin
        len_r <= bus.gate_len_i;
        timer <= GATE_W'(1);
        count <= '0;
        sat_r <= 1'b0;
      end else if (arm_hit) begin
        // the aligning edge is the first one counted
        timer <= GATE_W'(1);
        count <= CNT_W'(1);
        sat_r <= 1'b0;
      end else if (gate_step) begin
        timer <= timer + GATE_W'(1);
        if (edge_det) begin
          count <= cnt_inc;
          sat_r <= sat_r | cnt_max;
        end
      end else if (gate_close) begin
        // a continuous restart begins at gate cycle 1 with no dead cycle
        timer <= GATE_W'(1);
        count <= '0;
        sat_r <= 1'b0;
      end else if (abort) begin
        timer <= '0;
        count <= '0;
        sat_r <= 1'b0;
      end

      // a new result may replace one being consumed in the same cycle
      if (gate_close && (!valid_q || bus.result_ready_i)) begin
        result_q <= final_cnt;
        valid_q  <= 1'b1;
      end else if (valid_q && bus.result_ready_i) begin
        valid_q <= 1'b0;
      end

      if (start_acc) begin
        overrun_q <= 1'b0;
      end else if (gate_close && ((valid_q && !bus.result_ready_i) || final_sat)) begin
        overrun_q <= 1'b1;
      end
    end
  end

  assign bus.busy_o         = busy_q;
  assign bus.gate_o         = gate_q;
  assign bus.result_o       = result_q;
  assign bus.result_valid_o = valid_q;
  assign bus.overrun_o      = overrun_q;

endmodule
